// File: rtl/kernel_loader_pkg.sv
// Shared types and sizing for the kernel coefficient loader.
package kernel_loader_pkg;

    localparam int unsigned N_CH   = 16;
    localparam int unsigned N_COEF = 18;
    localparam int unsigned ADDR_W = 5;

    typedef logic [$clog2(N_CH)-1:0] ch_idx_t;
    typedef logic [ADDR_W-1:0]       coef_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_t;

endpackage

// File: rtl/kernel_loader_cnt.sv
// Nested coefficient/channel counter: coef is the inner index, ch the outer one.
module kernel_loader_cnt #(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned N_COEF = 18,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CH_W   = 4
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] coef_cnt,
    output logic [CH_W-1:0]   ch_cnt,
    output logic              last
);

    localparam logic [ADDR_W-1:0] CoefLast = ADDR_W'(N_COEF - 1);
    localparam logic [CH_W-1:0]   ChLast   = CH_W'(N_CH - 1);

    logic [ADDR_W-1:0] coef_q, coef_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    assign last = (ch_q == ChLast) && (coef_q == CoefLast);

    always_comb begin
        coef_d = coef_q;
        ch_d   = ch_q;
        if (clr) begin
            coef_d = '0;
            ch_d   = '0;
        end else if (inc) begin
            if (coef_q == CoefLast) begin
                coef_d = '0;
                // Explicit wrap so non-power-of-two channel counts also return to 0.
                ch_d   = last ? '0 : ch_q + 1'b1;
            end else begin
                coef_d = coef_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            coef_q <= '0;
            ch_q   <= '0;
        end else begin
            coef_q <= coef_d;
            ch_q   <= ch_d;
        end
    end

    assign coef_cnt = coef_q;
    assign ch_cnt   = ch_q;

endmodule

// File: rtl/kernel_loader.sv
// Write sequencer for the banked kernel coefficient store (channel-major stream).
// Define KERNEL_LOADER_LAST_CHECK_EN to add the s_last framing check and sticky err.
module kernel_loader #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned N_CH   = kernel_loader_pkg::N_CH,
    parameter int unsigned N_COEF = kernel_loader_pkg::N_COEF,
    parameter int unsigned ADDR_W = kernel_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_valid,
`ifdef KERNEL_LOADER_LAST_CHECK_EN
    input  logic              s_last,
    output logic              err,
`endif
    output logic              s_ready,
    output logic [WIDTH-1:0]  k_din,
    output logic [ADDR_W-1:0] k_waddr,
    output logic [N_CH-1:0]   k_we,
    output logic              busy,
    output logic              done
);

    import kernel_loader_pkg::*;

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t state_q, state_d;

    logic              accept;
    logic              cnt_clr;
    logic              cnt_last;
    logic [ADDR_W-1:0] coef_cnt;
    logic [CH_W-1:0]   ch_cnt;

    logic [N_CH-1:0]   k_we_q, k_we_d;
    logic [WIDTH-1:0]  k_din_q;
    logic [ADDR_W-1:0] k_waddr_q;

    assign s_ready = (state_q == StLoad) && !abort;
    assign accept  = s_valid && s_ready;

    kernel_loader_cnt #(
        .N_CH   (N_CH),
        .N_COEF (N_COEF),
        .ADDR_W (ADDR_W),
        .CH_W   (CH_W)
    ) u_cnt (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .clr       (cnt_clr),
        .inc       (accept),
        .coef_cnt  (coef_cnt),
        .ch_cnt    (ch_cnt),
        .last      (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_clr = 1'b1;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end else if (accept && cnt_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        k_we_d = '0;
        if (accept) begin
            k_we_d[ch_cnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q   <= StIdle;
            k_we_q    <= '0;
            k_din_q   <= '0;
            k_waddr_q <= '0;
        end else begin
            state_q <= state_d;
            k_we_q  <= k_we_d;
            if (accept) begin
                k_din_q   <= s_data;
                k_waddr_q <= coef_cnt;
            end
        end
    end

    assign k_we    = k_we_q;
    assign k_din   = k_din_q;
    assign k_waddr = k_waddr_q;
    assign busy    = (state_q == StLoad);
    // The final write becomes visible on the same edge that enters StDone.
    assign done    = (state_q == StDone);

`ifdef KERNEL_LOADER_LAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            err_q <= 1'b0;
        end else if (accept && (s_last != cnt_last)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// Self-checking bench for kernel_loader: vector table plus directed multi-cycle sequences.
// Covers the KERNEL_LOADER_LAST_CHECK_EN ports when that macro is defined.
module tb_kernel_loader;

    localparam int NB = 288;

    logic        clk;
    logic        arst_n_in;
    logic        start;
    logic        abort;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] k_din;
    logic [4:0]  k_waddr;
    logic [15:0] k_we;
    logic        busy;
    logic        done;
`ifdef KERNEL_LOADER_LAST_CHECK_EN
    logic        s_last;
    logic        err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    kernel_loader dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
`ifdef KERNEL_LOADER_LAST_CHECK_EN
        .s_last    (s_last),
        .err       (err),
`endif
        .s_ready   (s_ready),
        .k_din     (k_din),
        .k_waddr   (k_waddr),
        .k_we      (k_we),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic        valid;
        logic [15:0] data;
        logic        ready;
        logic [15:0] we;
        logic [4:0]  waddr;
        logic [15:0] din;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic abort_load();
        s_valid = 1'b0;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
    endtask

    // One beat with s_valid high; checks the registered write for beat index b.
    task automatic beat_check(input int b, input string tag);
        s_valid = 1'b1;
        s_data  = 16'(b);
        tick();
        check({tag, " we"},    32'(k_we),    32'(16'h1 << (b / 18)));
        check({tag, " waddr"}, 32'(k_waddr), 32'(b % 18));
        check({tag, " din"},   32'(k_din),   32'(b));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beat;
        int cyc;
        logic v;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0, 16'h0000, 5'd0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h1000, 1'b1, 16'h0001, 5'd0, 16'h1000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 16'h0000, 5'd0, 16'h1000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h1001, 1'b1, 16'h0001, 5'd1, 16'h1001, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h1002, 1'b1, 16'h0001, 5'd2, 16'h1002, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 16'h0000, 5'd2, 16'h1002, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h4444, 1'b0, 16'h0000, 5'd2, 16'h1002, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd2, 16'h1002, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h5000, 1'b1, 16'h0001, 5'd0, 16'h5000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 16'h5000, 1'b0, 1'b0};

        arst_n_in = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
`ifdef KERNEL_LOADER_LAST_CHECK_EN
        s_last    = 1'b0;
`endif
        tick();
        tick();
        check("rst k_we",    32'(k_we),    32'h0);
        check("rst k_din",   32'(k_din),   32'h0);
        check("rst k_waddr", 32'(k_waddr), 32'h0);
        check("rst busy",    32'(busy),    32'h0);
        check("rst done",    32'(done),    32'h0);
        check("rst s_ready", 32'(s_ready), 32'h0);
        arst_n_in = 1'b1;
        tick();

        // Table: idle/ignored events, start-over-abort, stall hold, abort drops beat.
        for (int i = 0; i < 12; i++) begin
            start   = vecs[i].start;
            abort   = vecs[i].abort;
            s_valid = vecs[i].valid;
            s_data  = vecs[i].data;
            #1;
            check($sformatf("vec%0d ready", i), 32'(s_ready), 32'(vecs[i].ready));
            tick();
            check($sformatf("vec%0d we", i),    32'(k_we),    32'(vecs[i].we));
            check($sformatf("vec%0d waddr", i), 32'(k_waddr), 32'(vecs[i].waddr));
            check($sformatf("vec%0d din", i),   32'(k_din),   32'(vecs[i].din));
            check($sformatf("vec%0d busy", i),  32'(busy),    32'(vecs[i].busy));
            check($sformatf("vec%0d done", i),  32'(done),    32'(vecs[i].done));
        end
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        tick();

        // Full load, s_valid held high.
        pulse_start();
        for (int b = 0; b < NB; b++) begin
            beat_check(b, "full");
            check("full done", 32'(done), 32'(b == NB - 1));
            check("full busy", 32'(busy), 32'(b != NB - 1));
        end
        s_valid = 1'b0;
        tick();
        check("full post done", 32'(done), 32'h0);
        check("full post we",   32'(k_we), 32'h0);
        check("full post busy", 32'(busy), 32'h0);

        // Full load with random stalls.
        pulse_start();
        beat = 0;
        cyc  = 0;
        while (beat < NB && cyc < 3000) begin
            v       = 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = 16'(beat);
            tick();
            cyc++;
            if (v) begin
                check("rnd we",    32'(k_we),    32'(16'h1 << (beat / 18)));
                check("rnd waddr", 32'(k_waddr), 32'(beat % 18));
                check("rnd din",   32'(k_din),   32'(beat));
                beat++;
            end else begin
                check("rnd stall we", 32'(k_we), 32'h0);
            end
            check("rnd done", 32'(done), 32'(v && beat == NB));
        end
        check("rnd beats", 32'(beat), 32'(NB));
        s_valid = 1'b0;
        tick();

        // Abort after 40 beats.
        pulse_start();
        for (int b = 0; b < 40; b++) beat_check(b, "abt");
        check("abt last we",    32'(k_we),    32'h0004);
        check("abt last waddr", 32'(k_waddr), 32'd3);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        #1;
        check("abt ready", 32'(s_ready), 32'h0);
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abt we",    32'(k_we),  32'h0);
        check("abt busy",  32'(busy),  32'h0);
        check("abt done",  32'(done),  32'h0);
        check("abt din",   32'(k_din), 32'd39);
        tick();
        check("abt idle done", 32'(done), 32'h0);
        pulse_start();
        beat_check(0, "abt restart");
        abort_load();

        // Asynchronous reset in the middle of beat 100.
        pulse_start();
        for (int b = 0; b < 100; b++) beat_check(b, "rst");
        s_valid = 1'b1;
        s_data  = 16'd100;
        #2;
        arst_n_in = 1'b0;
        #1;
        check("arst we",    32'(k_we),    32'h0);
        check("arst waddr", 32'(k_waddr), 32'h0);
        check("arst din",   32'(k_din),   32'h0);
        check("arst busy",  32'(busy),    32'h0);
        check("arst ready", 32'(s_ready), 32'h0);
        tick();
        tick();
        arst_n_in = 1'b1;
        tick();
        check("arst post ready", 32'(s_ready), 32'h0);
        check("arst post we",    32'(k_we),    32'h0);
        check("arst post busy",  32'(busy),    32'h0);
        check("arst post done",  32'(done),    32'h0);
        s_valid = 1'b0;
        pulse_start();
        beat_check(0, "arst restart");
        abort_load();

        // start during LOAD at beat 50 is ignored.
        pulse_start();
        for (int b = 0; b < 50; b++) beat_check(b, "ign");
        start = 1'b1;
        beat_check(50, "ign b50");
        start = 1'b0;
        beat_check(51, "ign b51");
        check("ign b51 we",    32'(k_we),    32'h0004);
        check("ign b51 waddr", 32'(k_waddr), 32'd15);
        abort_load();

`ifdef KERNEL_LOADER_LAST_CHECK_EN
        // Misplaced s_last at beat 100 sets sticky err; load still completes.
        pulse_start();
        check("err clr", 32'(err), 32'h0);
        for (int b = 0; b < NB; b++) begin
            s_last = (b == 100);
            beat_check(b, "lst1");
            check("lst1 err",  32'(err),  32'(b >= 100));
            check("lst1 done", 32'(done), 32'(b == NB - 1));
        end
        s_last  = 1'b0;
        s_valid = 1'b0;
        tick();
        check("lst1 sticky", 32'(err), 32'h1);
        // Correct s_last only on beat 287; start clears err.
        pulse_start();
        check("lst2 clr", 32'(err), 32'h0);
        for (int b = 0; b < NB; b++) begin
            s_last = (b == NB - 1);
            beat_check(b, "lst2");
        end
        check("lst2 err",  32'(err),  32'h0);
        check("lst2 done", 32'(done), 32'h1);
        s_last  = 1'b0;
        s_valid = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
